gray_step_checker: RTL

- Downstream consumer of the 4-bit binary-to-Gray converter stage.
- Registers the incoming Gray stream and decodes it back to binary.
- Checks that each new valid code differs from the previous one by at most one bit, reports count direction, and keeps a saturating error count.
- Moves to a fault state after repeated bad steps and re-locks on the next sample.

---
 rtl/gray_step_checker.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gray_step_checker.sv
// Two-stage Gray-code stream checker: registers incoming codes, decodes them to binary,
// classifies each step as up/down/hold/error and tracks lock state with a saturating error count.
module gray_step_checker #(
  parameter int unsigned W         = 4,
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [W-1:0]     g_in,
  output logic             out_valid,
  output logic [W-1:0]     b_out,
  output logic             up,
  output logic             down,
  output logic             hold,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIM = CW'(ERR_LIMIT);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_e;

  state_e            state_q, state_d;
  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      s1_g_q, s1_g_d;
  logic [W-1:0]      prev_g_q, prev_g_d;
  logic [CW-1:0]     consec_q, consec_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      b_out_q, b_out_d;
  logic              up_q, up_d, down_q, down_d, hold_q, hold_d, err_flag_q, err_flag_d;
  logic              locked_q, locked_d;

  logic [W-1:0]      cur_b, prev_b, prev_b_inc;
  int unsigned       diff;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int unsigned i = W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [W-1:0] x);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < W; i++) begin
      if (x[i]) cnt++;
    end
    return cnt;
  endfunction

  always_comb begin
    cur_b      = gray2bin(s1_g_q);
    prev_b     = gray2bin(prev_g_q);
    prev_b_inc = prev_b + {{(W-1){1'b0}}, 1'b1};
    diff       = popcount(s1_g_q ^ prev_g_q);
  end

  always_comb begin
    s1_valid_d  = in_valid;
    s1_g_d      = g_in;
    state_d     = state_q;
    prev_g_d    = prev_g_q;
    consec_d    = consec_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    b_out_d     = b_out_q;
    up_d        = 1'b0;
    down_d      = 1'b0;
    hold_d      = 1'b0;
    err_flag_d  = 1'b0;

    if (s1_valid_q) begin
      out_valid_d = 1'b1;
      b_out_d     = cur_b;
      prev_g_d    = s1_g_q;
      if (state_q != TRACK) begin
        state_d  = TRACK;
        consec_d = '0;
      end else if (diff == 0) begin
        hold_d   = 1'b1;
        consec_d = '0;
      end else if (diff == 1) begin
        consec_d = '0;
        if (cur_b == prev_b_inc) up_d = 1'b1;
        else                     down_d = 1'b1;
      end else begin
        err_flag_d = 1'b1;
        if (err_q != '1) err_d = err_q + 1'b1;
        // Entering FAULT re-arms the run counter so the re-lock starts clean.
        if (consec_q + 1'b1 >= LIM) begin
          state_d  = FAULT;
          consec_d = '0;
        end else begin
          consec_d = consec_q + 1'b1;
        end
      end
    end

    if (clr) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      up_d        = 1'b0;
      down_d      = 1'b0;
      hold_d      = 1'b0;
      err_flag_d  = 1'b0;
      state_d     = IDLE;
      consec_d    = '0;
      err_d       = '0;
    end

    locked_d = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s1_g_q      <= '0;
      prev_g_q    <= '0;
      consec_q    <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      b_out_q     <= '0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      hold_q      <= 1'b0;
      err_flag_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_g_q      <= s1_g_d;
      prev_g_q    <= prev_g_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      b_out_q     <= b_out_d;
      up_q        <= up_d;
      down_q      <= down_d;
      hold_q      <= hold_d;
      err_flag_q  <= err_flag_d;
      locked_q    <= locked_d;
    end
  end

  assign out_valid = out_valid_q;
  assign b_out     = b_out_q;
  assign up        = up_q;
  assign down      = down_q;
  assign hold      = hold_q;
  assign step_err  = err_flag_q;
  assign err_cnt   = err_q;
  assign locked    = locked_q;

endmodule
